// File: rtl/fx_pkg.sv
// Shared definitions for the fx (guitar effect) control blocks: widths,
// controller state encoding and the unity amplification constant.
package fx_pkg;

  localparam int AMP_W            = 31;
  localparam int AMP_FACTOR_UNITY = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    PEND   = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first.
// Operands are captured on start; done pulses W cycles later with the quotient.
module seq_divider #(
  parameter int W = 31
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem;
  logic [W-1:0]     quo;
  logic [W-1:0]     div;
  logic [CNT_W-1:0] cnt;
  logic             running;

  logic [W:0]       rem_shift;
  logic [W:0]       trial;
  logic [W-1:0]     rem_next;
  logic             q_bit;

  // The dividend shifts out of quo from the top while quotient bits shift in
  // at the bottom, so quo ends up holding the quotient after W steps.
  always_comb begin
    rem_shift = {rem, quo[W-1]};
    trial     = rem_shift - {1'b0, div};
    q_bit     = ~trial[W];
    rem_next  = q_bit ? trial[W-1:0] : rem_shift[W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem     <= '0;
      quo     <= '0;
      div     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      rem     <= '0;
      quo     <= dividend;
      div     <= divisor;
      cnt     <= CNT_W'(W);
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      rem <= rem_next;
      quo <= {quo[W-2:0], q_bit};
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        running <= 1'b0;
        done    <= 1'b1;
      end else begin
        done    <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/overdrive_param_ctrl.sv
// Overdrive parameter controller: accepts a parameter set, derives the
// amplification factor by sequential divide, and applies it on a sample tick.
module overdrive_param_ctrl
  import fx_pkg::*;
#(
  parameter int W = AMP_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_tick,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic         cfg_activate,
  input  logic         cfg_overdrive,
  input  logic [W-1:0] cfg_threshold,
  input  logic [W-1:0] cfg_neg_threshold,
  input  logic [W-1:0] cfg_max_amplitude,
  output logic         activate,
  output logic         overdrive,
  output logic [W-1:0] threshold,
  output logic [W-1:0] neg_threshold,
  output logic [W-1:0] max_amplitude,
  output logic [W-1:0] amp_factor,
  output logic         busy,
  output logic         cfg_err
);

  localparam logic [W-1:0] UNITY = W'(AMP_FACTOR_UNITY);

  // Handshake: a set transfers on any edge where cfg_valid && cfg_ready;
  // cfg_valid may stay high while cfg_ready is low and nothing is taken.
  ctrl_state_t state, state_next;

  logic         accept;
  logic         thr_zero;
  logic         reject;
  logic         good_accept;
  logic         div_start;
  logic         div_done;
  logic [W-1:0] div_quotient;
  logic         apply;

  logic         sh_activate;
  logic         sh_overdrive;
  logic [W-1:0] sh_threshold;
  logic [W-1:0] sh_neg_threshold;
  logic [W-1:0] sh_max_amplitude;
  logic [W-1:0] sh_factor;

  assign cfg_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = cfg_valid && cfg_ready;
  assign thr_zero    = (cfg_threshold == '0);
  assign reject      = accept && cfg_overdrive && thr_zero;
  assign good_accept = accept && !reject;
  assign div_start   = good_accept && cfg_overdrive;
  assign apply       = (state == PEND) && sample_tick;

  // The divider captures the live cfg operands on the handshake edge, the
  // same edge the shadow registers capture them, so both see one snapshot.
  seq_divider #(.W(W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (cfg_max_amplitude),
    .divisor  (cfg_threshold),
    .quotient (div_quotient),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (good_accept) begin
          state_next = cfg_overdrive ? DIVIDE : PEND;
        end
      end
      DIVIDE: begin
        if (div_done) begin
          state_next = PEND;
        end
      end
      PEND: begin
        if (sample_tick) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow set; the factor is provisionally unity and replaced by the
  // (clamped) quotient once the divide completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_activate      <= 1'b0;
      sh_overdrive     <= 1'b0;
      sh_threshold     <= '1;
      sh_neg_threshold <= '0;
      sh_max_amplitude <= '0;
      sh_factor        <= UNITY;
    end else if (good_accept) begin
      sh_activate      <= cfg_activate;
      sh_overdrive     <= cfg_overdrive;
      sh_threshold     <= cfg_threshold;
      sh_neg_threshold <= cfg_neg_threshold;
      sh_max_amplitude <= cfg_max_amplitude;
      sh_factor        <= UNITY;
    end else if ((state == DIVIDE) && div_done) begin
      sh_factor <= (div_quotient == '0) ? UNITY : div_quotient;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      activate      <= 1'b0;
      overdrive     <= 1'b0;
      threshold     <= '1;
      neg_threshold <= '0;
      max_amplitude <= '0;
      amp_factor    <= UNITY;
    end else if (apply) begin
      activate      <= sh_activate;
      overdrive     <= sh_overdrive;
      threshold     <= sh_threshold;
      neg_threshold <= sh_neg_threshold;
      max_amplitude <= sh_max_amplitude;
      amp_factor    <= sh_factor;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= reject;
    end
  end

endmodule

// File: doc/overdrive_param_ctrl.md
# overdrive_param_ctrl

Configuration controller that sits between the user-parameter front end (switches/keys decode) and the overdrive clipping datapath. It accepts a parameter set over a valid/ready handshake and computes the amplification factor `max_amplitude / threshold` with a multi-cycle sequential divider, so the datapath needs no combinational divide. It then applies the whole set atomically on the next audio sample boundary. The datapath never sees a half-updated parameter set or an in-progress quotient.

## Interface
- `W`, 31: amplitude/threshold/factor width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sample_tick`  in  1  one-cycle pulse marking an audio sample boundary.
- `cfg_valid`  in  1  parameter set offered.
- `cfg_ready`  out  1  controller can accept a set; high only in IDLE.
- `cfg_activate`  in  1  requested clipping enable.
- `cfg_overdrive`  in  1  requested mode: 1 = overdrive, 0 = compression.
- `cfg_threshold`  in  W  requested positive clip level.
- `cfg_neg_threshold`  in  W  requested negative clip level.
- `cfg_max_amplitude`  in  W  requested volume.
- `activate`  out  1  applied enable; reset 0.
- `overdrive`  out  1  applied mode; reset 0.
- `threshold`  out  W  applied threshold; reset all ones.
- `neg_threshold`  out  W  applied negative threshold; reset 0.
- `max_amplitude`  out  W  applied volume; reset 0.
- `amp_factor`  out  W  applied factor; reset 1.
- `busy`  out  1  a set is accepted but not yet applied; reset 0.
- `cfg_err`  out  1  one-cycle pulse when a set is rejected; reset 0.

## Operation
- States:
  - IDLE: `cfg_ready` = 1.
  - DIVIDE: computing the factor.
  - PEND: waiting for `sample_tick`.
- Acceptance: a handshake completes when `cfg_valid && cfg_ready`. On acceptance, all `cfg_*` inputs are captured into shadow registers. Later changes on `cfg_*` have no effect on the captured set.
- From IDLE after acceptance:
  - Captured overdrive = 1 and threshold != 0: go to DIVIDE.
  - Captured overdrive = 0: the shadow factor is set to 1 and the state goes to PEND. No divide is performed.
  - Captured overdrive = 1 and threshold = 0: the set is rejected. `cfg_err` pulses in the next cycle, the state stays IDLE, and the applied outputs are unchanged.
- Divider: unsigned restoring divide, one quotient bit per cycle, MSB first, exactly W cycles.
  - Quotient is W bits; the remainder is discarded.
  - A quotient of 0 (max < threshold) is clamped to 1.
  - When the divide finishes, the state goes to PEND.
- PEND:
  - On the first `sample_tick` seen in PEND, all six applied outputs load from the shadow registers in the same edge, and the state returns to IDLE.
  - `sample_tick` in IDLE or DIVIDE is ignored. It is not remembered.
- `busy` = (state != IDLE).
- `cfg_activate` = 0 still runs the full sequence. The factor is computed and applied, and the datapath ignores it.
- Reset asserted at any time, including mid-divide or in PEND:
  - All outputs take their reset values and the state goes to IDLE.
  - The pending set is discarded.
  - The shadow registers take the same values as the applied outputs.

## Timing
- Handshake at edge 0 with overdrive = 1:
  - The state is DIVIDE for edges 1..W.
  - PEND is entered at edge W+1 (edge 32 at the default width).
  - The outputs update on the first edge at which `sample_tick` = 1 while in PEND.
  - Earliest apply is edge W+2, with `cfg_ready` high again from that cycle.
- Handshake with overdrive = 0: PEND at edge 1, earliest apply at edge 2.
- Rejection: `cfg_err` is high for exactly the cycle after the handshake edge. `cfg_ready` stays 1.
- `sample_tick` on the same edge that enters PEND does not apply the set. The apply happens on a later tick.
- Outputs are registered, with no combinational path from `cfg_*` to the applied outputs. `cfg_ready` is decoded from the state register only.
- Back-to-back sets: the next handshake is possible in the first cycle after apply.

## Structure
- Shared package `fx_pkg`:
  - constant `AMP_W = 31`;
  - state enum `ctrl_state_t` {IDLE, DIVIDE, PEND};
  - constant `AMP_FACTOR_UNITY = 1`.
- Sub-module `seq_divider` (parameter `W`):
  - inputs: `clk`, `reset`, `start`, `dividend`, `divisor`;
  - outputs: `quotient`, `done` (a one-cycle pulse W cycles after `start`).
  - It is reusable by the other fx blocks.
- The top level contains the FSM, the shadow registers and the apply registers.

## Test plan
- Reset, then observe: `amp_factor` = 1, `threshold` = 31'h7FFFFFFF, `activate` = 0, `busy` = 0, `cfg_ready` = 1.
- Overdrive set: max = 1000, threshold = 300, ticks every 40 cycles.
  - Required: `amp_factor` = 3 and `threshold` = 300 appear together on the first tick at or after cycle 33.
  - Required: no output changes before that tick.
- Compression set: overdrive = 0, threshold = 500, tick at cycle 5.
  - Required: the outputs apply at the cycle-5 edge with `amp_factor` = 1.
- Overdrive with threshold = 0:
  - Required: `cfg_err` high for exactly one cycle and the outputs unchanged.
  - Then max = 100, threshold = 400: required `amp_factor` = 1 (clamp).
- Reset deasserted→asserted at cycle 15 of a divide:
  - Required: the outputs return to their reset values, and no apply happens on later ticks.
- Check `cfg_valid` held high while busy:
  - Required: no second handshake until after apply.
  - Required: `cfg_*` changes during DIVIDE do not alter the applied result.
